coeff_decomposer_pipe: RTL and testbench

// Parametrised, pipelined successor to coeff_decomposer. Splits LANES packed coefficients per beat into
//   (r0, r1) by Decompose, Power2Round or UseHint, selected per beat; sec_lvl 2/3/5 is also per beat.

---
 rtl/dilithium_pkg.sv | 29 ++
 rtl/decompose_lane.sv | 124 ++++++++++++
 rtl/coeff_decomposer_pipe.sv | 61 ++++++
 tb/tb_coeff_decomposer_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dilithium_pkg.sv
// Shared constants and beat-control types for the coefficient decomposer.
package dilithium_pkg;
  localparam int Q         = 8380417;
  localparam int N1        = 190464;     // 2*gamma2 at sec_lvl 2
  localparam int N2        = 523776;     // 2*gamma2 at sec_lvl 3/5
  localparam int Q_N1_DIFF = Q - N1;
  localparam int Q_N2_DIFF = Q - N2;
  localparam int K         = 41;
  localparam int M1        = 11545611;   // floor(2^K / N1)
  localparam int M2        = 4198404;    // floor(2^K / N2)
  localparam int D         = 13;

  localparam logic [2:0] SEC_LVL_2 = 3'd2;
  localparam logic [2:0] SEC_LVL_3 = 3'd3;
  localparam logic [2:0] SEC_LVL_5 = 3'd5;

  typedef enum logic [1:0] {
    MODE_DECOMPOSE   = 2'd0,
    MODE_POWER2ROUND = 2'd1,
    MODE_USE_HINT    = 2'd2,
    MODE_PASS        = 2'd3
  } mode_e;

  // hi selects the sec_lvl 3/5 gamma2
  typedef struct packed {
    mode_e mode;
    logic  hi;
  } ctl_t;
endpackage

// File: rtl/decompose_lane.sv
// One coefficient lane: quotient estimate, centred remainder, then Q-1 fixup / hint / output encoding.
module decompose_lane
  import dilithium_pkg::*;
#(
  parameter int COEFF_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  ctl_t               ctl0,
  input  ctl_t               ctl1,
  input  ctl_t               ctl2,
  input  logic [COEFF_W-1:0] r,
  input  logic               h,
  output logic [COEFF_W-1:0] r0_out,
  output logic [COEFF_W-1:0] r1_out
);
  logic [31:0] rz;
  logic [47:0] prod;
  logic [9:0]  t0;

  assign rz   = 32'(r);
  assign prod = 48'(rz) * (ctl0.hi ? 48'(M2) : 48'(M1));
  assign t0   = (ctl0.mode == MODE_POWER2ROUND) ? 10'(rz >> D) : 10'(prod >> K);

  logic [31:0] r_s1;
  logic [9:0]  t_s1;
  logic        h_s1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= '0;
      t_s1 <= '0;
      h_s1 <= 1'b0;
    end else if (en) begin
      r_s1 <= rz;
      t_s1 <= t0;
      h_s1 <= h;
    end
  end

  // t may undershoot the true quotient by one; fix that, then centre into (-g, g]
  logic [31:0]        g, g2, rem, rp;
  logic [10:0]        q;
  logic signed [31:0] r0c;

  always_comb begin
    if (ctl1.mode == MODE_POWER2ROUND) begin
      g  = 32'd4096;
      g2 = 32'd8192;
    end else if (ctl1.hi) begin
      g  = 32'(N2 / 2);
      g2 = 32'(N2);
    end else begin
      g  = 32'(N1 / 2);
      g2 = 32'(N1);
    end
    rem = r_s1 - 32'(t_s1) * g2;
    q   = 11'(t_s1);
    rp  = rem;
    if (rem >= g2) begin
      q  = q + 11'd1;
      rp = rem - g2;
    end
    r0c = signed'(rp);
    if (rp > g) begin
      r0c = signed'(rp - g2);
      q   = q + 11'd1;
    end
  end

  logic [31:0]        r_s2;
  logic signed [24:0] r0_s2;
  logic [10:0]        q_s2;
  logic               h_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2  <= '0;
      r0_s2 <= '0;
      q_s2  <= '0;
      h_s2  <= 1'b0;
    end else if (en) begin
      r_s2  <= r_s1;
      r0_s2 <= 25'(r0c);
      q_s2  <= q;
      h_s2  <= h_s1;
    end
  end

  logic signed [31:0] r0f, diff;
  logic [10:0]        r1f, m;
  logic [31:0]        out0;

  always_comb begin
    r0f  = {{7{r0_s2[24]}}, r0_s2};
    r1f  = q_s2;
    m    = ctl2.hi ? 11'd16 : 11'd44;
    diff = signed'(r_s2) - r0f;
    if (ctl2.mode != MODE_POWER2ROUND && diff == Q - 1) begin
      r1f = '0;
      r0f = r0f - 32'sd1;
    end
    if (ctl2.mode == MODE_USE_HINT && h_s2) begin
      if (r0f > 0) r1f = (r1f == m - 11'd1) ? 11'd0 : r1f + 11'd1;
      else         r1f = (r1f == 11'd0) ? m - 11'd1 : r1f - 11'd1;
    end
    out0 = (r0f < 0) ? 32'(r0f + Q) : 32'(r0f);
    if (ctl2.mode == MODE_PASS) begin
      out0 = r_s2;
      r1f  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r0_out <= '0;
      r1_out <= '0;
    end else if (en) begin
      r0_out <= COEFF_W'(out0);
      r1_out <= COEFF_W'(r1f);
    end
  end
endmodule

// File: rtl/coeff_decomposer_pipe.sv
// LANES-wide, 3-stage Decompose/Power2Round/UseHint pipe with stall-the-whole-pipe backpressure.
module coeff_decomposer_pipe
  import dilithium_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int COEFF_W = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               sec_lvl,
  input  logic [1:0]               mode,
  input  logic [LANES-1:0]         hint,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [LANES*COEFF_W-1:0] di,
  output logic [LANES*COEFF_W-1:0] doa,
  output logic [LANES*COEFF_W-1:0] dob,
  output logic                     valid_o,
  input  logic                     ready_i
);
  localparam int STAGES = 3;

  logic              en;
  logic [STAGES:1]   vld_pipe;
  ctl_t              ctl0, ctl1, ctl2;
  logic [LANES-1:0]  hv;

  // unknown sec_lvl codes fall into the wide-gamma2 class
  assign ctl0    = '{mode: mode_e'(mode), hi: (sec_lvl != SEC_LVL_2)};
  assign hv      = hint;
  assign valid_o = vld_pipe[STAGES];
  assign en      = ready_i | ~valid_o;
  assign ready_o = en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      ctl1     <= '0;
      ctl2     <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], valid_i};
      ctl1     <= ctl0;
      ctl2     <= ctl1;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    decompose_lane #(.COEFF_W(COEFF_W)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .ctl0   (ctl0),
      .ctl1   (ctl1),
      .ctl2   (ctl2),
      .r      (di[k*COEFF_W +: COEFF_W]),
      .h      (hv[k]),
      .r0_out (doa[k*COEFF_W +: COEFF_W]),
      .r1_out (dob[k*COEFF_W +: COEFF_W])
    );
  end
endmodule

// File: tb/tb_coeff_decomposer_pipe.sv
// Bench for coeff_decomposer_pipe: directed vectors, stall/reset scenarios and a random scoreboard run.
module tb_coeff_decomposer_pipe;
  localparam int LANES = 4;
  localparam int CW    = 24;
  localparam int Q     = 8380417;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sec_lvl;
  logic [1:0]  mode;
  logic [3:0]  hint;
  logic        valid_i, ready_o, valid_o, ready_i;
  logic [95:0] di, doa, dob;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  coeff_decomposer_pipe #(.LANES(LANES), .COEFF_W(CW)) dut (
    .clk(clk), .rst(rst), .sec_lvl(sec_lvl), .mode(mode), .hint,
    .valid_i(valid_i), .ready_o(ready_o), .di(di), .doa(doa), .dob(dob),
    .valid_o(valid_o), .ready_i(ready_i)
  );

  typedef struct {
    logic [95:0] a;
    logic [95:0] b;
  } exp_t;

  // Textbook Decompose / Power2Round / UseHint with plain integer division
  function automatic void ref_model(input int r, input int md, input int lvl, input bit h,
                                    output int o0, output int o1);
    int g, g2, r0, r1, m;
    if (md == 3) begin o0 = r; o1 = 0; return; end
    if (md == 1) g = 4096;
    else if (lvl == 2) g = (Q - 1) / 88;
    else g = (Q - 1) / 32;
    g2 = 2 * g;
    r0 = r % g2;
    if (r0 > g) r0 = r0 - g2;
    r1 = (r - r0) / g2;
    if (md != 1 && r - r0 == Q - 1) begin r1 = 0; r0 = r0 - 1; end
    if (md == 2 && h) begin
      m = (lvl == 2) ? 44 : 16;
      if (r0 > 0) r1 = (r1 + 1) % m;
      else        r1 = (r1 + m - 1) % m;
    end
    o0 = (r0 < 0) ? r0 + Q : r0;
    o1 = r1;
  endfunction

  function automatic exp_t ref_beat(input logic [95:0] d, input int md, input int lvl, input logic [3:0] h);
    exp_t e;
    int o0, o1;
    for (int k = 0; k < LANES; k++) begin
      ref_model(int'(d[k*CW +: CW]), md, lvl, h[k], o0, o1);
      e.a[k*CW +: CW] = CW'(o0);
      e.b[k*CW +: CW] = CW'(o1);
    end
    return e;
  endfunction

  function automatic logic [95:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {CW'(l3), CW'(l2), CW'(l1), CW'(l0)};
  endfunction

  function automatic int rand_coeff();
    int v;
    case ($urandom_range(7, 0))
      0: v = Q - 1;
      1: v = 0;
      2: v = int'(95232 * $urandom_range(88, 0)) + int'($urandom_range(2, 0)) - 1;
      3: v = int'(261888 * $urandom_range(32, 0)) + int'($urandom_range(2, 0)) - 1;
      4: v = int'(4096 * $urandom_range(2046, 0)) + int'($urandom_range(2, 0)) - 1;
      default: v = int'($urandom_range(Q - 1, 0));
    endcase
    if (v < 0) v = 0;
    if (v > Q - 1) v = Q - 1;
    return v;
  endfunction

  // Drive one beat into an empty pipe and return its outputs and edge count to valid_o
  task automatic run_beat(input logic [2:0] lvl, input logic [1:0] md, input logic [3:0] h,
                          input logic [95:0] d, output logic [95:0] a, output logic [95:0] b,
                          output int lat);
    @(negedge clk);
    sec_lvl = lvl; mode = md; hint = h; di = d; valid_i = 1'b1; ready_i = 1'b1;
    lat = -1; a = '0; b = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      valid_i = 1'b0;
      if (valid_o) begin lat = c; a = doa; b = dob; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; valid_i = 1'b0; ready_i = 1'b0; sec_lvl = 3'd2; mode = 2'd0; hint = '0; di = '0;
    #12;
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid_o got=%b want=0", valid_o); end
    checks++; if (doa !== '0) begin failures++; $display("FAIL reset_doa got=%h want=0", doa); end
    checks++; if (dob !== '0) begin failures++; $display("FAIL reset_dob got=%h want=0", dob); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready_o got=%b want=1", ready_o); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_decompose_lvl2();
    logic [95:0] a, b; int lat;
    int ea[4] = '{0, 95232, 8285186, 8380416};
    int eb[4] = '{0, 0, 1, 0};
    run_beat(3'd2, 2'd0, 4'b0000, pack4(0, 95232, 95233, 8380416), a, b, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL latency got=%0d want=3", lat); end
    for (int k = 0; k < LANES; k++) begin
      checks++; if (a[k*CW +: CW] !== CW'(ea[k])) begin failures++; $display("FAIL dec_l2_doa lane%0d got=%0d want=%0d", k, a[k*CW +: CW], ea[k]); end
      checks++; if (b[k*CW +: CW] !== CW'(eb[k])) begin failures++; $display("FAIL dec_l2_dob lane%0d got=%0d want=%0d", k, b[k*CW +: CW], eb[k]); end
    end
  endtask

  task automatic test_decompose_lvl3();
    logic [95:0] a, b; int lat;
    logic [2:0] lvls[3] = '{3'd3, 3'd5, 3'd7};
    int ea[4] = '{8118530, 8380416, 0, 261888};
    int eb[4] = '{1, 0, 1, 0};
    for (int i = 0; i < 3; i++) begin
      run_beat(lvls[i], 2'd0, 4'b0000, pack4(261889, 8380416, 523776, 261888), a, b, lat);
      for (int k = 0; k < LANES; k++) begin
        checks++; if (a[k*CW +: CW] !== CW'(ea[k])) begin failures++; $display("FAIL dec_l%0d_doa lane%0d got=%0d want=%0d", lvls[i], k, a[k*CW +: CW], ea[k]); end
        checks++; if (b[k*CW +: CW] !== CW'(eb[k])) begin failures++; $display("FAIL dec_l%0d_dob lane%0d got=%0d want=%0d", lvls[i], k, b[k*CW +: CW], eb[k]); end
      end
    end
  endtask

  task automatic test_power2round();
    logic [95:0] a, b; int lat;
    int ea[4] = '{4096, 8376322, 0, 0};
    int eb[4] = '{0, 1, 1023, 1};
    run_beat(3'd2, 2'd1, 4'b1111, pack4(4096, 4097, 8380416, 8192), a, b, lat);
    for (int k = 0; k < LANES; k++) begin
      checks++; if (a[k*CW +: CW] !== CW'(ea[k])) begin failures++; $display("FAIL p2r_doa lane%0d got=%0d want=%0d", k, a[k*CW +: CW], ea[k]); end
      checks++; if (b[k*CW +: CW] !== CW'(eb[k])) begin failures++; $display("FAIL p2r_dob lane%0d got=%0d want=%0d", k, b[k*CW +: CW], eb[k]); end
    end
  endtask

  task automatic test_use_hint();
    logic [95:0] a, b; int lat;
    int ea2[4] = '{0, 8285186, 8285186, 8380416};
    int eb2[4] = '{43, 0, 1, 43};
    int ea3[4] = '{0, 261888, 8380416, 1};
    int eb3[4] = '{15, 1, 0, 0};
    run_beat(3'd2, 2'd2, 4'b1011, pack4(0, 95233, 95233, 8380416), a, b, lat);
    for (int k = 0; k < LANES; k++) begin
      checks++; if (a[k*CW +: CW] !== CW'(ea2[k])) begin failures++; $display("FAIL hint_l2_doa lane%0d got=%0d want=%0d", k, a[k*CW +: CW], ea2[k]); end
      checks++; if (b[k*CW +: CW] !== CW'(eb2[k])) begin failures++; $display("FAIL hint_l2_dob lane%0d got=%0d want=%0d", k, b[k*CW +: CW], eb2[k]); end
    end
    run_beat(3'd3, 2'd2, 4'b1011, pack4(0, 261888, 8380416, 7856641), a, b, lat);
    for (int k = 0; k < LANES; k++) begin
      checks++; if (a[k*CW +: CW] !== CW'(ea3[k])) begin failures++; $display("FAIL hint_l3_doa lane%0d got=%0d want=%0d", k, a[k*CW +: CW], ea3[k]); end
      checks++; if (b[k*CW +: CW] !== CW'(eb3[k])) begin failures++; $display("FAIL hint_l3_dob lane%0d got=%0d want=%0d", k, b[k*CW +: CW], eb3[k]); end
    end
  endtask

  task automatic test_backpressure();
    exp_t sb[$];
    exp_t e;
    int md[6]  = '{0, 1, 2, 3, 0, 2};
    int lv[6]  = '{2, 3, 2, 5, 3, 2};
    int ecyc[6] = '{3, 8, 9, 10, 11, 12};
    int sent = 0, got = 0;
    bit stalled = 0;
    logic [95:0] pa = '0, pb = '0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      ready_i = !(c >= 4 && c < 8);
      if (sent < 6) begin
        valid_i = 1'b1; mode = 2'(md[sent]); sec_lvl = 3'(lv[sent]); hint = 4'($urandom_range(15, 0));
        di = pack4(rand_coeff(), rand_coeff(), rand_coeff(), rand_coeff());
      end else valid_i = 1'b0;
      #1;
      if (stalled) begin
        checks++; if (valid_o !== 1'b1 || doa !== pa || dob !== pb) begin failures++; $display("FAIL bp_hold cyc%0d got=%b/%h/%h want=1/%h/%h", c, valid_o, doa, dob, pa, pb); end
      end
      stalled = valid_o && !ready_i;
      if (stalled) begin
        pa = doa; pb = dob;
        checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready_o cyc%0d got=%b want=0", c, ready_o); end
      end
      if (valid_o && ready_i) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL bp_extra_beat cyc%0d got=beat want=none", c); end
        else begin
          e = sb.pop_front();
          if (doa !== e.a || dob !== e.b || c != ecyc[got]) begin
            failures++; $display("FAIL bp_beat%0d cyc=%0d/%0d doa=%h/%h dob=%h/%h (got/want)", got, c, ecyc[got], doa, e.a, dob, e.b);
          end
        end
        got++;
      end
      if (valid_i && ready_o) begin sb.push_back(ref_beat(di, int'(mode), int'(sec_lvl), hint)); sent++; end
    end
    checks++; if (got != 6) begin failures++; $display("FAIL bp_count got=%0d want=6", got); end
    @(negedge clk); valid_i = 1'b0; ready_i = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_midstream();
    int seen = 0;
    ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      valid_i = 1'b1; mode = 2'd0; sec_lvl = 3'd2; hint = '0; di = pack4(300000, 300000, 300000, 300000);
    end
    @(negedge clk); valid_i = 1'b0; #1;
    checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL rstmid_pre_valid got=%b want=1", valid_o); end
    rst = 1'b0; #1;
    checks++; if (valid_o !== 1'b0 || doa !== '0 || dob !== '0) begin failures++; $display("FAIL rstmid_clear got=%b/%h/%h want=0/0/0", valid_o, doa, dob); end
    @(posedge clk); #1;
    checks++; if (valid_o !== 1'b0 || doa !== '0 || dob !== '0) begin failures++; $display("FAIL rstmid_edge got=%b/%h/%h want=0/0/0", valid_o, doa, dob); end
    @(negedge clk); rst = 1'b1;
    repeat (8) begin @(negedge clk); if (valid_o) seen++; end
    checks++; if (seen != 0) begin failures++; $display("FAIL rstmid_stale got=%0d beats want=0", seen); end
  endtask

  task automatic test_random();
    localparam int N = 10000;
    exp_t sb[$];
    exp_t e;
    int sent = 0, got = 0, cyc = 0;
    bit stalled = 0;
    logic [95:0] pa = '0, pb = '0;
    while ((sent < N || got < N) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      ready_i = ($urandom_range(3, 0) != 0);
      if (sent < N) begin
        valid_i = ($urandom_range(3, 0) != 0);
        mode = 2'($urandom_range(3, 0)); sec_lvl = 3'($urandom_range(7, 0)); hint = 4'($urandom_range(15, 0));
        di = pack4(rand_coeff(), rand_coeff(), rand_coeff(), rand_coeff());
      end else valid_i = 1'b0;
      #1;
      checks++; if (ready_o !== (ready_i || !valid_o)) begin failures++; $display("FAIL rnd_ready_o cyc%0d got=%b want=%b", cyc, ready_o, ready_i || !valid_o); end
      if (stalled) begin
        checks++; if (valid_o !== 1'b1 || doa !== pa || dob !== pb) begin failures++; $display("FAIL rnd_hold cyc%0d got=%b/%h/%h want=1/%h/%h", cyc, valid_o, doa, dob, pa, pb); end
      end
      stalled = valid_o && !ready_i;
      pa = doa; pb = dob;
      if (valid_o && ready_i) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL rnd_extra_beat cyc%0d got=beat want=none", cyc); end
        else begin
          e = sb.pop_front();
          if (doa !== e.a || dob !== e.b) begin
            failures++; $display("FAIL rnd_beat%0d doa=%h want=%h dob=%h want=%h", got, doa, e.a, dob, e.b);
          end
        end
        got++;
      end
      if (valid_i && ready_o) begin sb.push_back(ref_beat(di, int'(mode), int'(sec_lvl), hint)); sent++; end
    end
    checks++; if (got != N || sb.size() != 0) begin failures++; $display("FAIL rnd_drain got=%0d pending=%0d want=%0d/0", got, sb.size(), N); end
    @(negedge clk); valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decompose_lvl2();
    test_decompose_lvl3();
    test_power2round();
    test_use_hint();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
